// File: rtl/io_bank.sv
// io_bank: memory-mapped peripheral bank for the 0x80000000-0x800000FF I/O window.
// Holds a GPIO output register, a synchronized GPIO input, a free-running cycle
// counter, a down-counting timer with interrupt and an 8N1 UART transmitter.
// Reads are combinational so load data returns in the same cycle as the request.
module io_bank #(
    parameter int GPIO_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        io_addr,
    input  logic              io_en,
    input  logic              io_we,
    input  logic [31:0]       io_data_write,
    output logic [31:0]       io_data_read,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              uart_tx,
    output logic              irq
);

    localparam int BT_W = $clog2(CLKS_PER_BIT);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(CLKS_PER_BIT - 1);

    localparam logic [5:0] A_GPIO_OUT = 6'h00;
    localparam logic [5:0] A_GPIO_IN  = 6'h01;
    localparam logic [5:0] A_CYCLE    = 6'h02;
    localparam logic [5:0] A_LOAD     = 6'h03;
    localparam logic [5:0] A_CTRL     = 6'h04;
    localparam logic [5:0] A_COUNT    = 6'h05;
    localparam logic [5:0] A_UDATA    = 6'h06;
    localparam logic [5:0] A_USTAT    = 6'h07;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [5:0]        word;
    logic              wr;
    logic              unused_addr_bits;

    logic [GPIO_W-1:0] gpio_q;
    logic [GPIO_W-1:0] sync_1;
    logic [GPIO_W-1:0] sync_2;
    logic [31:0]       cycle;

    logic [31:0]       timer_load;
    logic [31:0]       count;
    logic              t_en;
    logic              t_reload;
    logic              t_flag;
    logic              t_irq_en;

    uart_state_t       state, state_next;
    logic [BT_W-1:0]   bit_timer, bit_timer_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shift, shift_next;
    logic              tx_q, tx_next;
    logic              bit_end;
    logic              busy;

    // Byte offset bits [1:0] do not participate in decode (word access only).
    assign unused_addr_bits = ^io_addr[1:0];
    assign word     = io_addr[7:2];
    assign wr       = io_en & io_we;
    assign busy     = (state != IDLE);
    assign gpio_out = gpio_q;
    assign uart_tx  = tx_q;
    assign irq      = t_flag & t_irq_en;

    // GPIO output register, two-flop input synchronizer and free-running cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q <= '0;
            sync_1 <= '0;
            sync_2 <= '0;
            cycle  <= '0;
        end else begin
            if (wr && word == A_GPIO_OUT) gpio_q <= io_data_write[GPIO_W-1:0];
            sync_1 <= gpio_in;
            sync_2 <= sync_1;
            cycle  <= cycle + 32'd1;
        end
    end

    // Timer: later assignments take priority, so the hardware flag set beats a W1C,
    // the one-shot en clear beats a software en write, and a LOAD write beats reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_load <= '0;
            count      <= '0;
            t_en       <= 1'b0;
            t_reload   <= 1'b0;
            t_flag     <= 1'b0;
            t_irq_en   <= 1'b0;
        end else begin
            if (wr && word == A_LOAD) timer_load <= io_data_write;
            if (wr && word == A_CTRL) begin
                t_en     <= io_data_write[0];
                t_reload <= io_data_write[1];
                t_irq_en <= io_data_write[3];
                if (io_data_write[2]) t_flag <= 1'b0;
            end
            if (t_en) begin
                if (count != '0) begin
                    count <= count - 32'd1;
                end else begin
                    t_flag <= 1'b1;
                    if (t_reload) count <= timer_load;
                    else          t_en  <= 1'b0;
                end
            end
            if (wr && word == A_LOAD) count <= io_data_write;
        end
    end

    // UART state register; tx is registered so the serial line never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_next;
            bit_timer <= bit_timer_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            tx_q      <= tx_next;
        end
    end

    // UART next-state logic: every state or data bit lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_next     = state;
        bit_timer_next = bit_timer;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        tx_next        = 1'b1;
        bit_end        = (bit_timer == BT_LAST);
        case (state)
            IDLE: begin
                if (wr && word == A_UDATA) begin
                    state_next     = START;
                    shift_next     = io_data_write[7:0];
                    bit_timer_next = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next     = DATA;
                    bit_timer_next = '0;
                    bit_idx_next   = '0;
                end else begin
                    bit_timer_next = bit_timer + BT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_timer_next = '0;
                    if (bit_idx == 3'd7) state_next   = STOP;
                    else                 bit_idx_next = bit_idx + 3'd1;
                end else begin
                    bit_timer_next = bit_timer + BT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next     = IDLE;
                    bit_timer_next = '0;
                end else begin
                    bit_timer_next = bit_timer + BT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[bit_idx_next];
            default: tx_next = 1'b1;
        endcase
    end

    // Combinational read mux; zero when no access is presented.
    always_comb begin
        io_data_read = '0;
        if (io_en) begin
            case (word)
                A_GPIO_OUT: io_data_read[GPIO_W-1:0] = gpio_q;
                A_GPIO_IN:  io_data_read[GPIO_W-1:0] = sync_2;
                A_CYCLE:    io_data_read = cycle;
                A_LOAD:     io_data_read = timer_load;
                A_CTRL:     io_data_read[3:0] = {t_irq_en, t_flag, t_reload, t_en};
                A_COUNT:    io_data_read = count;
                A_USTAT:    io_data_read[0] = busy;
                default:    io_data_read = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bank.sv
// tb_io_bank: scoreboard bench for io_bank. Register reads and UART line samples
// are queued as expectations when stimulus is driven and checked on the falling edge.
module tb_io_bank;

    localparam int GPIO_W = 8;
    localparam int CPB    = 4;

    localparam logic [7:0] A_GPIO_OUT = 8'h00;
    localparam logic [7:0] A_GPIO_IN  = 8'h04;
    localparam logic [7:0] A_CYCLE    = 8'h08;
    localparam logic [7:0] A_LOAD     = 8'h0C;
    localparam logic [7:0] A_CTRL     = 8'h10;
    localparam logic [7:0] A_COUNT    = 8'h14;
    localparam logic [7:0] A_UDATA    = 8'h18;
    localparam logic [7:0] A_USTAT    = 8'h1C;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        io_addr = '0;
    logic              io_en = 1'b0;
    logic              io_we = 1'b0;
    logic [31:0]       io_data_write = '0;
    logic [31:0]       io_data_read;
    logic [GPIO_W-1:0] gpio_in = '0;
    logic [GPIO_W-1:0] gpio_out;
    logic              uart_tx;
    logic              irq;

    int checks = 0;
    int errors = 0;

    string       rd_tag_q[$];
    logic [31:0] rd_exp_q[$];
    logic        uart_q[$];
    logic [31:0] cyc_model;

    io_bank #(.GPIO_W(GPIO_W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .io_addr(io_addr),
        .io_en(io_en),
        .io_we(io_we),
        .io_data_write(io_data_write),
        .io_data_read(io_data_read),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .uart_tx(uart_tx),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference cycle counter.
    always @(posedge clk) begin
        if (reset) cyc_model <= '0;
        else       cyc_model <= cyc_model + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pending register reads are compared on the falling edge.
    always @(negedge clk) begin
        if (rd_exp_q.size() > 0) begin
            check(rd_tag_q.pop_front(), io_data_read, rd_exp_q.pop_front());
        end
    end

    // Expected UART line level, one entry per clock.
    always @(negedge clk) begin
        if (uart_q.size() > 0) begin
            check("uart_tx", {31'd0, uart_tx}, {31'd0, uart_q.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_addr       = a;
        io_data_write = d;
        io_en         = 1'b1;
        io_we         = 1'b1;
        tick();
        io_en = 1'b0;
        io_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] e);
        io_addr = a;
        io_we   = 1'b0;
        io_en   = 1'b1;
        rd_tag_q.push_back(tag);
        rd_exp_q.push_back(e);
        @(negedge clk);
        #1;
        io_en = 1'b0;
    endtask

    task automatic uart_send(input logic [7:0] d);
        logic b;
        wr(A_UDATA, {24'd0, d});
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      b = 1'b0;
            else if (i == 9) b = 1'b1;
            else             b = d[i-1];
            for (int k = 0; k < CPB; k++) uart_q.push_back(b);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and every offset
        repeat (2) tick();
        reset = 1'b0;
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("rst_rd_idle", io_data_read, 32'd0);
        rd("rst_cycle", A_CYCLE, cyc_model);
        rd("rst_gpio_out_rd", A_GPIO_OUT, 32'd0);
        rd("rst_gpio_in_rd", A_GPIO_IN, 32'd0);
        rd("rst_load", A_LOAD, 32'd0);
        rd("rst_ctrl", A_CTRL, 32'd0);
        rd("rst_count", A_COUNT, 32'd0);
        rd("rst_udata", A_UDATA, 32'd0);
        rd("rst_ustat", A_USTAT, 32'd0);
        rd("unmapped_20", 8'h20, 32'd0);
        rd("unmapped_fc", 8'hFC, 32'd0);

        // GPIO output
        wr(A_GPIO_OUT, 32'h0000_00A5);
        check("gpio_out_pin", {24'd0, gpio_out}, 32'h0000_00A5);
        rd("gpio_out_rd_lowbits", 8'h01, 32'h0000_00A5);
        io_addr = A_GPIO_OUT;
        io_en   = 1'b0;
        #1;
        check("rd_zero_no_en", io_data_read, 32'd0);

        // GPIO input synchronizer
        tick();
        gpio_in = 8'h3C;
        rd("gpio_in_edge0", A_GPIO_IN, 32'd0);
        rd("gpio_in_edge1", A_GPIO_IN, 32'd0);
        rd("gpio_in_edge2", A_GPIO_IN, 32'h0000_003C);

        // Cycle counter, two reads five cycles apart
        tick();
        rd("cycle_a", A_CYCLE, cyc_model);
        repeat (5) tick();
        rd("cycle_b", A_CYCLE, cyc_model);

        // One-shot timer
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'h9);
        rd("oneshot_cnt3", A_COUNT, 32'd3);
        rd("oneshot_cnt2", A_COUNT, 32'd2);
        rd("oneshot_cnt1", A_COUNT, 32'd1);
        rd("oneshot_cnt0", A_COUNT, 32'd0);
        check("oneshot_irq_pre", {31'd0, irq}, 32'd0);
        rd("oneshot_ctrl_flag", A_CTRL, 32'hC);
        check("oneshot_irq", {31'd0, irq}, 32'd1);
        rd("oneshot_cnt_hold", A_COUNT, 32'd0);
        wr(A_CTRL, 32'h4);
        check("oneshot_irq_clr", {31'd0, irq}, 32'd0);
        rd("oneshot_ctrl_clr", A_CTRL, 32'h0);

        // Auto-reload timer
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'hB);
        rd("reload_c1", A_CTRL, 32'hB);
        rd("reload_c2", A_CTRL, 32'hB);
        rd("reload_c3", A_CTRL, 32'hB);
        rd("reload_set", A_CTRL, 32'hF);
        rd("reload_cnt", A_COUNT, 32'd1);
        wr(A_CTRL, 32'hF);
        rd("reload_w1c", A_CTRL, 32'hB);
        wr(A_CTRL, 32'hF);
        rd("reload_set_wins", A_CTRL, 32'hF);
        check("reload_irq", {31'd0, irq}, 32'd1);
        rd("reload_cnt2", A_COUNT, 32'd1);
        tick();
        wr(A_LOAD, 32'd7);
        rd("load_beats_reload", A_COUNT, 32'd7);
        wr(A_CTRL, 32'h0);

        // UART frame, dropped write, back-to-back write
        uart_send(8'h5A);
        repeat (9) tick();
        wr(A_UDATA, 32'h0000_00FF);
        rd("uart_busy_mid", A_USTAT, 32'd1);
        repeat (29) tick();
        rd("uart_busy_last", A_USTAT, 32'd1);
        tick();
        rd("uart_busy_fall", A_USTAT, 32'd0);
        uart_send(8'hC3);
        rd("uart_b2b_busy", A_USTAT, 32'd1);

        // Reset mid-frame
        repeat (6) tick();
        reset = 1'b1;
        uart_q.delete();
        tick();
        reset = 1'b0;
        check("midrst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("midrst_gpio_out", {24'd0, gpio_out}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        rd("midrst_cycle", A_CYCLE, cyc_model);
        rd("midrst_ustat", A_USTAT, 32'd0);
        rd("midrst_load", A_LOAD, 32'd0);
        rd("midrst_ctrl", A_CTRL, 32'd0);
        rd("midrst_count", A_COUNT, 32'd0);
        rd("midrst_gpio_out_rd", A_GPIO_OUT, 32'd0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
